ptw_multilevel: RTL
===================

Name: ptw_multilevel

Overview:
Parametrised hardware page-table walker, the successor to the fixed two-level PTW. It serves one TLB-miss request at a time and walks LEVELS levels of Sv32-style page tables from a runtime root PPN. It returns the leaf PTE, the level at which the leaf was found, and a fault code. It supports superpages, a flush/abort input, and an optional last-walk cache. It sits between the TLB miss port and the memory request/response port.

Parameters:
VA_W, 32, virtual address width; must equal 12 + LEVELS*VPN_W.
PA_W, 34, physical address width of mem_addr_o.
LEVELS, 2, number of page-table levels, 2..4.
VPN_W, 10, VPN bits per level; PTE size fixed at 4 bytes.
PPN_W, 22, PPN field width inside the PTE (PTE[31:10]).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
root_ppn_i  in  PPN_W  root table PPN; sampled when a request is accepted
flush_i  in  1  abort current walk; invalidate walk cache
ptw_req_valid_i  in  1  walk request valid
ptw_req_ready_o  out  1  walker idle, can accept
ptw_vaddr_i  in  VA_W  virtual address to translate
ptw_resp_valid_o  out  1  result valid
ptw_resp_ready_i  in  1  TLB accepts result
ptw_pte_o  out  32  leaf PTE, or the faulting PTE
ptw_level_o  out  2  level of leaf/fault; 0 = last level
ptw_fault_o  out  2  0 none, 1 invalid, 2 misaligned superpage, 3 reserved encoding
mem_req_valid_o  out  1  PTE fetch request
mem_req_ready_i  in  1  memory accepts request
mem_addr_o  out  PA_W  PTE physical address
mem_resp_valid_i  in  1  PTE data valid
mem_resp_ready_o  out  1  walker accepts data
mem_data_i  in  32  PTE data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, on rst_n.
- Reset state: IDLE. ptw_req_ready_o=1. All other valids 0. Data outputs 0. Walk cache invalid.
- States and transitions:
  - IDLE: on req handshake, latch vaddr and root_ppn_i; base = root_ppn<<12; lvl = LEVELS-1; go to REQ.
  - REQ: mem_req_valid_o=1; mem_addr_o = base + VPN[lvl]*4, zero-extended to PA_W. On handshake go to WAIT. mem_addr_o is held stable while valid.
  - WAIT: mem_resp_ready_o=1. On handshake, decode the PTE.
  - RESP: ptw_resp_valid_o=1; outputs held stable until ptw_resp_ready_i, then return to IDLE.
- PTE decode (V=bit0, R=1, W=2, X=3):
  - V=0 → fault 1.
  - W=1 and R=0 → fault 3.
  - R or X set → leaf. If lvl>0, PPN bits [lvl*VPN_W-1:0] must be 0, else fault 2.
  - Otherwise, lvl==0 → fault 1.
  - Otherwise non-leaf: base = PPN<<12; lvl--; go to REQ.
- Latency: minimum 2 cycles per level with zero-wait memory, plus 1 cycle in RESP.
- Every fault or leaf goes to RESP with ptw_pte_o = fetched PTE and ptw_level_o = lvl.
- Flush:
  - IDLE: cache invalidated only.
  - REQ without handshake in the same cycle: go to IDLE.
  - REQ with handshake in the same cycle, or WAIT: go to DRAIN. DRAIN holds mem_resp_ready_o=1, discards one response, then goes to IDLE. ptw_req_ready_o=0 in DRAIN.
  - RESP: drop the response, go to IDLE.
- rst_n low mid-walk aborts immediately. The memory side must also be reset.
- Requests are never accepted outside IDLE. ptw_vaddr_i is ignored once latched.

Optional Feature:
- Macro: PTW_WALK_CACHE_EN.
- When defined: a one-entry cache holds {valid, root_ppn, VPN[LEVELS-1:1], level-0 table base}. It is written when a level-1 non-leaf PTE is decoded. On request acceptance, a hit skips directly to REQ at lvl=0 using the cached base. The cache is invalidated by flush_i and rst_n.
- When undefined: no cache storage; every walk starts at the root.

Decomposition:
- Package ptw_pkg: state enum (IDLE, REQ, WAIT, DRAIN, RESP), fault code constants, PTE bit index constants, PTE_BYTES=4, helper function for VPN slice extraction.
- Sub-module ptw_pte_decode: combinational decode of PTE plus lvl into {leaf, fault code, next base}.

Test Plan:
- Two-level walk. Setup: root_ppn_i=0x1; mem[0x1000]=0x00000801; mem[0x2004]=0x0000300F. Stimulus: vaddr 0x00001000. Response: mem addrs 0x1000 then 0x2004; pte=0x0000300F, level 0, fault 0.
- Superpage. Setup: mem[0x1004]=0x0000000F. Stimulus: vaddr 0x00400000. Response: one access; pte=0x0000000F, level 1, fault 0.
- Misaligned superpage. Setup: mem[0x1008]=0x0000040F. Stimulus: vaddr 0x00800000. Response: fault 2, level 1.
- Invalid and reserved entries. Setup: mem[0x100C]=0. Stimulus: vaddr 0x00C00000. Response: fault 1, level 1, pte=0. Then mem[0x2008]=0x00000005 with vaddr 0x00002000 → fault 3, level 0.
- Flush in WAIT with memory stalled 5 cycles. Response: response discarded, no ptw_resp_valid_o, ptw_req_ready_o returns 1 after the memory beat; the next walk is correct.
- With PTW_WALK_CACHE_EN: repeat vaddr 0x00001000 → only one memory access (0x2004). After a flush pulse → two accesses again.

Source files
------------

// File: rtl/ptw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ptw_pkg
// Purpose  : Shared constants and helpers for the multi-level page-table walker.
// Revision : 1.0 - initial release
// ============================================================================
package ptw_pkg;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_REQ   = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_RESP  = 3'd4;

    localparam logic [1:0] c_FAULT_NONE       = 2'd0;
    localparam logic [1:0] c_FAULT_INVALID    = 2'd1;
    localparam logic [1:0] c_FAULT_MISALIGNED = 2'd2;
    localparam logic [1:0] c_FAULT_RESERVED   = 2'd3;

    localparam int c_PTE_V       = 0;
    localparam int c_PTE_R       = 1;
    localparam int c_PTE_W       = 2;
    localparam int c_PTE_X       = 3;
    localparam int c_PTE_PPN_LSB = 10;

    localparam int PTE_BYTES = 4;

    // VPN field for a given level; level 0 sits just above the page offset.
    function automatic logic [31:0] vpn_slice(input logic [63:0] vaddr,
                                              input logic [1:0]  lvl,
                                              input int          vpn_w);
        vpn_slice = 32'(vaddr >> (12 + int'(lvl) * vpn_w)) & ((32'd1 << vpn_w) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptw_pte_decode.sv
`default_nettype none
// ============================================================================
// Module   : ptw_pte_decode
// Purpose  : Combinational PTE decode: leaf detection, fault code, next base.
// Revision : 1.0 - initial release
// ============================================================================
module ptw_pte_decode
    import ptw_pkg::*;
#(
    parameter int PA_W  = 34,
    parameter int VPN_W = 10,
    parameter int PPN_W = 22
) (
    input  logic [31:0]     pte,
    input  logic [1:0]      lvl,
    output logic            leaf,
    output logic [1:0]      fault,
    output logic [PA_W-1:0] next_base
);

    logic [PPN_W-1:0] w_ppn;
    logic [PPN_W-1:0] w_mask;
    logic             w_unused;

    assign w_ppn     = pte[c_PTE_PPN_LSB +: PPN_W];
    assign next_base = PA_W'({w_ppn, 12'b0});
    assign w_unused  = ^pte[9:4];

    // PPN bits that a superpage at this level must leave clear.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PPN_W; i++) begin
            w_mask[i] = (i < int'(lvl) * VPN_W);
        end
    end

    always_comb begin
        leaf  = 1'b0;
        fault = c_FAULT_NONE;
        if (!pte[c_PTE_V]) begin
            fault = c_FAULT_INVALID;
        end else if (pte[c_PTE_W] && !pte[c_PTE_R]) begin
            fault = c_FAULT_RESERVED;
        end else if (pte[c_PTE_R] || pte[c_PTE_X]) begin
            leaf = 1'b1;
            if ((lvl != 2'd0) && ((w_ppn & w_mask) != '0)) begin
                fault = c_FAULT_MISALIGNED;
            end
        end else if (lvl == 2'd0) begin
            fault = c_FAULT_INVALID;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ptw_multilevel.sv
`default_nettype none
// ============================================================================
// Module   : ptw_multilevel
// Purpose  : LEVELS-deep Sv32-style page-table walker with flush/abort.
//            Define PTW_WALK_CACHE_EN for a one-entry last-walk cache.
// Revision : 1.0 - initial release
// ============================================================================
module ptw_multilevel
    import ptw_pkg::*;
#(
    parameter int VA_W   = 32,
    parameter int PA_W   = 34,
    parameter int LEVELS = 2,
    parameter int VPN_W  = 10,
    parameter int PPN_W  = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PPN_W-1:0] root_ppn_i,
    input  logic             flush_i,
    input  logic             ptw_req_valid_i,
    output logic             ptw_req_ready_o,
    input  logic [VA_W-1:0]  ptw_vaddr_i,
    output logic             ptw_resp_valid_o,
    input  logic             ptw_resp_ready_i,
    output logic [31:0]      ptw_pte_o,
    output logic [1:0]       ptw_level_o,
    output logic [1:0]       ptw_fault_o,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic [PA_W-1:0]  mem_addr_o,
    input  logic             mem_resp_valid_i,
    output logic             mem_resp_ready_o,
    input  logic [31:0]      mem_data_i
);

    localparam logic [1:0] c_TOP_LVL = 2'(LEVELS - 1);

    logic [2:0]       r_state;
    logic [VA_W-1:0]  r_vaddr;
    logic [PA_W-1:0]  r_base;
    logic [1:0]       r_lvl;
    logic [31:0]      r_pte;
    logic [1:0]       r_fault;

    logic [VPN_W-1:0] w_vpn;
    logic [PA_W-1:0]  w_mem_addr;
    logic [PA_W-1:0]  w_root_base;
    logic             w_leaf;
    logic [1:0]       w_fault;
    logic [PA_W-1:0]  w_next_base;
    logic             w_done;
    logic             w_wc_hit;
    logic [PA_W-1:0]  w_wc_base;

    assign w_vpn       = VPN_W'(vpn_slice(64'(r_vaddr), r_lvl, VPN_W));
    assign w_mem_addr  = r_base + PA_W'(w_vpn) * PA_W'(PTE_BYTES);
    assign w_root_base = PA_W'({root_ppn_i, 12'b0});
    assign w_done      = w_leaf || (w_fault != c_FAULT_NONE);

    ptw_pte_decode #(
        .PA_W  (PA_W),
        .VPN_W (VPN_W),
        .PPN_W (PPN_W)
    ) u_decode (
        .pte       (mem_data_i),
        .lvl       (r_lvl),
        .leaf      (w_leaf),
        .fault     (w_fault),
        .next_base (w_next_base)
    );

`ifdef PTW_WALK_CACHE_EN
    localparam int c_HI_W = (LEVELS - 1) * VPN_W;

    logic             r_wc_valid;
    logic [PPN_W-1:0] r_wc_root;
    logic [c_HI_W-1:0] r_wc_vpn;
    logic [PA_W-1:0]  r_wc_base;
    logic [PPN_W-1:0] r_root;
    logic             w_wc_write;

    // Capture the level-0 table base as the walk descends out of level 1.
    assign w_wc_write = (r_state == c_ST_WAIT) && mem_resp_valid_i && !flush_i
                        && !w_done && (r_lvl == 2'd1);
    assign w_wc_hit   = r_wc_valid && !flush_i && (r_wc_root == root_ppn_i)
                        && (r_wc_vpn == ptw_vaddr_i[VA_W-1 -: c_HI_W]);
    assign w_wc_base  = r_wc_base;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_root <= '0;
        end else if ((r_state == c_ST_IDLE) && ptw_req_valid_i) begin
            r_root <= root_ppn_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_wc_valid <= 1'b0;
            r_wc_root  <= '0;
            r_wc_vpn   <= '0;
            r_wc_base  <= '0;
        end else if (w_wc_write) begin
            r_wc_valid <= 1'b1;
            r_wc_root  <= r_root;
            r_wc_vpn   <= r_vaddr[VA_W-1 -: c_HI_W];
            r_wc_base  <= w_next_base;
        end
    end
`else
    assign w_wc_hit  = 1'b0;
    assign w_wc_base = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_vaddr <= '0;
            r_base  <= '0;
            r_lvl   <= 2'd0;
            r_pte   <= '0;
            r_fault <= c_FAULT_NONE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (ptw_req_valid_i) begin
                        r_vaddr <= ptw_vaddr_i;
                        r_state <= c_ST_REQ;
                        if (w_wc_hit) begin
                            r_base <= w_wc_base;
                            r_lvl  <= 2'd0;
                        end else begin
                            r_base <= w_root_base;
                            r_lvl  <= c_TOP_LVL;
                        end
                    end
                end
                c_ST_REQ: begin
                    if (flush_i) begin
                        r_state <= mem_req_ready_i ? c_ST_DRAIN : c_ST_IDLE;
                    end else if (mem_req_ready_i) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    // A beat arriving with the flush is consumed here, so nothing is left to drain.
                    if (mem_resp_valid_i) begin
                        if (flush_i) begin
                            r_state <= c_ST_IDLE;
                        end else if (w_done) begin
                            r_pte   <= mem_data_i;
                            r_fault <= w_fault;
                            r_state <= c_ST_RESP;
                        end else begin
                            r_base  <= w_next_base;
                            r_lvl   <= r_lvl - 2'd1;
                            r_state <= c_ST_REQ;
                        end
                    end else if (flush_i) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (mem_resp_valid_i) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RESP: begin
                    if (flush_i || ptw_resp_ready_i) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign ptw_req_ready_o  = (r_state == c_ST_IDLE);
    assign mem_req_valid_o  = (r_state == c_ST_REQ);
    assign mem_addr_o       = (r_state == c_ST_REQ) ? w_mem_addr : '0;
    assign mem_resp_ready_o = (r_state == c_ST_WAIT) || (r_state == c_ST_DRAIN);
    assign ptw_resp_valid_o = (r_state == c_ST_RESP);
    assign ptw_pte_o        = r_pte;
    assign ptw_level_o      = r_lvl;
    assign ptw_fault_o      = r_fault;

endmodule
`default_nettype wire
